// File: rtl/rx_hex_display_pkg.sv
// Shared types and segment constants for the UART byte hex display.
// Segments are active-low, bit6=a down to bit0=g.
package rx_hex_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_R     = 7'b1111010;

endpackage

// File: rtl/rx_hex_display_hex_to_seg7.sv
// Nibble to active-low seven-segment pattern (a..g in bits 6..0).
module hex_to_seg7
  import rx_hex_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/rx_hex_display.sv
// Shows the last two good UART bytes in hex on a 4-digit display,
// with a timed "Err" pattern after a framing error.
module rx_hex_display
  import rx_hex_display_pkg::*;
#(
  parameter int ERR_HOLD_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_ferr,
  input  logic       clear,
  output logic [6:0] digit0,
  output logic [6:0] digit1,
  output logic [6:0] digit2,
  output logic [6:0] digit3,
  output logic [7:0] byte_count
);

  localparam int TW = (ERR_HOLD_CYCLES < 1) ? 1
                    : $clog2(ERR_HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD = TW'(ERR_HOLD_CYCLES);

  state_e        state_q, state_d;
  logic [15:0]   hist_q, hist_d;
  logic [1:0]    held_q, held_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [27:0]   dig_q, dig_d;
  logic [6:0]    seg_n [4];

  logic good, bad;
  assign good = rx_valid & ~rx_ferr;
  assign bad  = rx_valid &  rx_ferr;

  for (genvar i = 0; i < 4; i++) begin : g_dec
    hex_to_seg7 u_dec (
      .hex (hist_q[4*i +: 4]),
      .seg (seg_n[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      held_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      dig_q   <= {4{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      held_q  <= held_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end

  // held_q[0]: newest byte valid, held_q[1]: previous byte valid
  always_comb begin
    hist_d = hist_q;
    held_d = held_q;
    cnt_d  = cnt_q;
    if (clear) begin
      hist_d = '0;
      held_d = '0;
      cnt_d  = '0;
    end else if (good) begin
      hist_d = {hist_q[7:0], rx_data};
      held_d = {held_q[0], 1'b1};
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (clear) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bad) begin
            state_d = ST_ERR;
            timer_d = HOLD;
          end else if (good) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (bad) begin
            state_d = ST_ERR;
            timer_d = HOLD;
          end
        end
        ST_ERR: begin
          if (bad) begin
            timer_d = HOLD;
          end else if (timer_q == '0) begin
            state_d = held_d[0] ? ST_SHOW : ST_IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    dig_d = {4{SEG_BLANK}};
    if (!clear) begin
      case (state_q)
        ST_SHOW: dig_d = {
          held_q[1] ? seg_n[3] : SEG_BLANK,
          held_q[1] ? seg_n[2] : SEG_BLANK,
          seg_n[1],
          seg_n[0]
        };
        ST_ERR:  dig_d = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
        default: dig_d = {4{SEG_BLANK}};
      endcase
    end
  end

  assign digit0     = dig_q[6:0];
  assign digit1     = dig_q[13:7];
  assign digit2     = dig_q[20:14];
  assign digit3     = dig_q[27:21];
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_rx_hex_display.sv
// Bench for rx_hex_display: directed spec vectors plus random
// traffic checked against a byte-list reference model.
module tb_rx_hex_display;

  localparam int N    = 8;
  localparam int NONE = 1000;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ferr  = 1'b0;
  logic       clear    = 1'b0;
  logic [6:0] digit0, digit1, digit2, digit3;
  logic [7:0] byte_count;

  rx_hex_display #(.ERR_HOLD_CYCLES(N)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .clear      (clear),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;

  localparam logic [6:0]  BL    = 7'b1111111;
  localparam logic [27:0] ALLBL = {BL, BL, BL, BL};
  localparam logic [27:0] ERRP  = {7'b0110000, 7'b1111010,
                                   7'b1111010, BL};

  logic [6:0] hexseg [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_checks = 0;
  int n_pass   = 0;
  int errs     = 0;

  // model: good bytes since clear, last two of them, edges since last error
  int         ngood   = 0;
  int         err_age = NONE;
  logic [7:0] b_new   = 8'h00;
  logic [7:0] b_prev  = 8'h00;

  logic [27:0] dig_all;
  assign dig_all = {digit3, digit2, digit1, digit0};

  function automatic logic [27:0] disp();
    logic [27:0] r;
    if (err_age <= N) r = ERRP;
    else if (ngood == 0) r = ALLBL;
    else begin
      r[13:7] = hexseg[b_new[7:4]];
      r[6:0]  = hexseg[b_new[3:0]];
      r[27:21] = (ngood >= 2) ? hexseg[b_prev[7:4]] : BL;
      r[20:14] = (ngood >= 2) ? hexseg[b_prev[3:0]] : BL;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [27:0] o,
                     input logic [27:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed %h expected %h", tag, o, e);
  endtask

  task automatic model_reset();
    ngood   = 0;
    err_age = NONE;
  endtask

  task automatic step(input logic v, input logic f,
                      input logic [7:0] d, input logic c);
    logic [27:0] e;
    rx_valid = v;
    rx_ferr  = f;
    rx_data  = d;
    clear    = c;
    @(posedge clock);
    e = c ? ALLBL : disp();
    if (c) model_reset();
    else begin
      if (v && f) err_age = 0;
      else if (err_age < NONE) err_age++;
      if (v && !f) begin
        b_prev = b_new;
        b_new  = d;
        ngood++;
      end
    end
    #1;
    chk("digits", dig_all, e);
    chk("count", {20'd0, byte_count}, 28'(ngood % 256));
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic stepc(input logic v, input logic f,
                       input logic [7:0] d);
    step(v, f, d, 1'b0);
    if (dig_all === ERRP) errs++;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("reset_digits", dig_all, ALLBL);
    chk("reset_count", {20'd0, byte_count}, 28'd0);
    #9 reset_n = 1'b1;
    model_reset();

    idle(20);

    step(1'b1, 1'b0, 8'h3A, 1'b0);
    idle(1);
    chk("byte_3a", dig_all, {BL, BL, 7'b0000110, 7'b0001000});

    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h12, 1'b0);
    step(1'b1, 1'b0, 8'hEF, 1'b0);
    idle(1);
    chk("bytes_12_ef", dig_all,
        {7'b1001111, 7'b0010010, 7'b0110000, 7'b0111000});
    chk("count_2", {20'd0, byte_count}, 28'd2);

    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h12, 1'b0);
    idle(1);
    errs = 0;
    stepc(1'b1, 1'b1, 8'hC3);
    stepc(1'b0, 1'b0, 8'h00);
    stepc(1'b0, 1'b0, 8'h00);
    stepc(1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 11; i++) stepc(1'b0, 1'b0, 8'h00);
    chk("err_dwell", 28'(errs), 28'(N + 1));
    chk("after_err", dig_all,
        {7'b1001111, 7'b0010010, 7'b0100100, 7'b0100100});
    chk("after_err_cnt", {20'd0, byte_count}, 28'd2);

    step(1'b1, 1'b0, 8'h77, 1'b1);
    idle(1);
    chk("clear_prio", dig_all, ALLBL);
    chk("clear_cnt", {20'd0, byte_count}, 28'd0);
    step(1'b1, 1'b0, 8'h9B, 1'b0);
    idle(1);
    chk("idle_after_clr", dig_all,
        {BL, BL, 7'b0000100, 7'b1100000});

    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 256; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
    idle(1);
    chk("wrap_cnt", {20'd0, byte_count}, 28'd0);

    step(1'b1, 1'b0, 8'hA5, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_dig", dig_all, ALLBL);
    chk("midreset_cnt", {20'd0, byte_count}, 28'd0);
    model_reset();
    #2 reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h4D, 1'b0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      logic v, f, c;
      v = ($urandom_range(0, 99) < 35);
      f = v && ($urandom_range(0, 99) < 20);
      c = ($urandom_range(0, 99) < 3);
      step(v, f, 8'($urandom), c);
    end
    idle(N + 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_hex_display.md
RX_HEX_DISPLAY -- requirements
Module: rx_hex_display

Interface
REQ-001 Parameter: ERR_HOLD_CYCLES, default 50_000_000, number of clock cycles the error pattern is held (minimum 1).
REQ-002 Port: clock, input, 1, single system clock; all state updates on its rising edge.
REQ-003 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port: rx_data, input, 8, received UART byte; qualified by rx_valid.
REQ-005 Port: rx_valid, input, 1, single-cycle strobe marking rx_data/rx_ferr valid.
REQ-006 Port: rx_ferr, input, 1, framing error flag for the strobed byte; ignored when rx_valid=0.
REQ-007 Port: clear, input, 1, synchronous clear of history, count and display.
REQ-008 Port: digit0..digit3, output, 7 each, active-low segment patterns for the 4-digit scanner.
- Bit6=a through bit0=g.
- digit0 is the rightmost digit.
REQ-009 Port: byte_count, output, 8, number of good bytes received since reset/clear; wraps modulo 256.

Function
REQ-010 The block SHALL keep a 16-bit history: newest byte in bits[7:0], previous byte in bits[15:8].
REQ-011 Each good byte (rx_valid=1, rx_ferr=0) SHALL set history <= {history[7:0], rx_data} and byte_count <= byte_count+1.
REQ-012 States SHALL be IDLE (no good byte yet), SHOW and ERR.
REQ-013 Digit outputs SHALL be registered.
- A strobe sampled at edge k is reflected on the digit outputs immediately after edge k+1.
- Latency is exactly one cycle.
REQ-014 In IDLE, all digits SHALL be blank (7'b1111111).
REQ-015 In SHOW:
- digit0/digit1 SHALL show the hex low/high nibble of the newest byte.
- digit2/digit3 SHALL show the previous byte's nibbles, or blank if only one good byte has been received since reset/clear.
REQ-016 Hex encodings SHALL be:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
REQ-017 IDLE SHALL go to SHOW on a good byte.
REQ-018 Any state SHALL go to ERR on rx_valid=1 with rx_ferr=1.
- The hold timer SHALL load ERR_HOLD_CYCLES.
- The erroneous byte SHALL NOT enter history or byte_count.
REQ-019 In ERR:
- Displays: digit3=E, digit2=r (1111010), digit1=r, digit0=blank.
- The timer SHALL decrement each cycle.
- A further error SHALL reload the timer to ERR_HOLD_CYCLES.
REQ-020 Good bytes arriving in ERR SHALL update history and byte_count without changing the displayed pattern.
REQ-021 When the timer reaches 0, ERR SHALL exit on that edge.
- Go to SHOW if any good byte has been held, else IDLE.
- Total ERR dwell is ERR_HOLD_CYCLES+1 cycles (the entry cycle plus ERR_HOLD_CYCLES decrement cycles).
REQ-022 clear=1 SHALL have priority over rx_valid in the same cycle.
- History, byte-held flags and byte_count SHALL go to 0, the timer to 0, and the state to IDLE.
- A coincident byte SHALL be discarded.
REQ-023 byte_count SHALL wrap from 255 to 0 without side effects.
REQ-024 The timer SHALL be wide enough for ERR_HOLD_CYCLES with no overflow.

Reset
REQ-025 While reset_n=0, the block SHALL asynchronously force:
- state=IDLE, history=0, byte-held flags=0, timer=0, byte_count=0
- all digits=1111111 (blank)
REQ-026 On reset_n deassertion, the first strobe SHALL be accepted on the first rising edge of clock.
REQ-027 Reset asserted mid-ERR or mid-update SHALL discard all state with no partial update.

Structure
REQ-028 The shared package SHALL hold:
- the state enum (IDLE, SHOW, ERR)
- the 7-bit segment constants SEG_BLANK, SEG_E, SEG_R
- the segment bit-order definition
REQ-029 Hex-to-segment decoding SHALL live in one combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), instantiated four times.

Verification (ERR_HOLD_CYCLES=8 for simulation)
REQ-030 Reset, no stimulus -> all digits 1111111, byte_count=0, for 20 cycles.
REQ-031 Good byte 0x3A -> one cycle later: digit0=0001000, digit1=0000110, digit2=digit3=1111111, byte_count=1.
REQ-032 Bytes 0x12 then 0xEF ->
- digit3=1001111, digit2=0010010, digit1=0110000, digit0=0111000
- byte_count=2
REQ-033 After 0x12, send an error byte, then 0x55 three cycles later ->
- "Err" shown for exactly 9 cycles.
- Then digits show 5,5,2,1 (right to left), byte_count=2.
REQ-034 clear and good byte 0x77 in the same cycle -> all blank, byte_count=0, state IDLE.
REQ-035 256 good bytes -> byte_count returns to 0; the display shows the last two bytes.
